// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues req/ack data-port accesses, aligns and extends
// load data, builds store byte enables and registers results into the MEM/WB register.
module mem_stage #(
    parameter int XLEN     = 32,
    parameter int ADDR_LSB = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [2:0]      in_funct3,
    input  logic            in_MemRead,
    input  logic            in_MemWrite,
    input  logic            in_RegWrite,
    input  logic [1:0]      in_MemtoReg,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_pc_write,
    input  logic [XLEN-1:0] in_immediate,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall_req,
    output logic            misalign_err,
    output logic            wb_valid,
    output logic            wb_RegWrite,
    output logic [1:0]      wb_MemtoReg,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_data_in,
    output logic [XLEN-1:0] wb_pc_write,
    output logic [XLEN-1:0] wb_immediate
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t     state_reg, state_next;
    size_t      size;
    logic       ld_unsigned;
    logic       is_mem, aligned, mem_op, misalign;
    logic [1:0] lane;
    logic [7:0] rbyte [4];
    logic [3:0] be_byte;
    logic [XLEN-1:0] load_data;

    assign lane = in_alu_result[1:0];

    // Stores only know SB/SH; everything else on a store is a word. Loads likewise default to LW.
    always_comb begin
        size        = SZ_W;
        ld_unsigned = 1'b0;
        if (in_MemWrite) begin
            case (in_funct3)
                3'b000:  size = SZ_B;
                3'b001:  size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            case (in_funct3)
                3'b000:  size = SZ_B;
                3'b001:  size = SZ_H;
                3'b100:  begin size = SZ_B; ld_unsigned = 1'b1; end
                3'b101:  begin size = SZ_H; ld_unsigned = 1'b1; end
                default: size = SZ_W;
            endcase
        end
    end

    always_comb begin
        case (size)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~lane[0];
            default: aligned = (lane == 2'b00);
        endcase
    end

    assign is_mem    = in_valid & (in_MemRead | in_MemWrite);
    assign mem_op    = is_mem & aligned;
    assign misalign  = is_mem & ~aligned;
    assign dmem_req  = mem_op & ~rst;
    assign stall_req = dmem_req & ~dmem_ack;
    assign dmem_we   = in_MemWrite;
    assign dmem_addr = {in_alu_result[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi]   = dmem_rdata[8*gi +: 8];
            assign be_byte[gi] = (lane == gi[1:0]);
        end
    endgenerate

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = in_store_data;
        if (in_MemWrite) begin
            case (size)
                SZ_B: begin
                    dmem_be    = be_byte;
                    dmem_wdata = {4{in_store_data[7:0]}};
                end
                SZ_H: begin
                    dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{in_store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [15:0] half;
        half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size)
            SZ_B:    load_data = ld_unsigned ? {24'd0, rbyte[lane]}
                                             : {{24{rbyte[lane][7]}}, rbyte[lane]};
            SZ_H:    load_data = ld_unsigned ? {16'd0, half} : {{16{half[15]}}, half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (dmem_req && !dmem_ack) state_next = S_WAIT;
            S_WAIT: if (!dmem_req || dmem_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // While stalled the register takes a bubble; payload fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= 2'd0;
            wb_rd_addr    <= 5'd0;
            wb_alu_result <= '0;
            wb_data_in    <= '0;
            wb_pc_write   <= '0;
            wb_immediate  <= '0;
            misalign_err  <= 1'b0;
        end else if (stall_req) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            wb_valid      <= in_valid;
            wb_RegWrite   <= in_RegWrite & in_valid & ~misalign;
            wb_MemtoReg   <= in_MemtoReg;
            wb_rd_addr    <= in_rd_addr;
            wb_alu_result <= in_alu_result;
            wb_data_in    <= load_data;
            wb_pc_write   <= in_pc_write;
            wb_immediate  <= in_immediate;
            misalign_err  <= misalign;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, wait states,
// misalignment, back-to-back ALU op and reset during an outstanding access.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_MemRead, in_MemWrite, in_RegWrite;
    logic [31:0] in_alu_result, in_store_data, in_pc_write, in_immediate;
    logic [2:0]  in_funct3;
    logic [1:0]  in_MemtoReg;
    logic [4:0]  in_rd_addr;
    logic        dmem_req, dmem_we, dmem_ack, stall_req, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_RegWrite;
    logic [1:0]  wb_MemtoReg;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_alu_result, wb_data_in, wb_pc_write, wb_immediate;

    int total = 0;
    int bad   = 0;

    mem_stage #(.XLEN(32), .ADDR_LSB(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_funct3(in_funct3), .in_MemRead(in_MemRead),
        .in_MemWrite(in_MemWrite), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
        .in_rd_addr(in_rd_addr), .in_pc_write(in_pc_write), .in_immediate(in_immediate),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_req(stall_req), .misalign_err(misalign_err),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_rd_addr(wb_rd_addr), .wb_alu_result(wb_alu_result), .wb_data_in(wb_data_in),
        .wb_pc_write(wb_pc_write), .wb_immediate(wb_immediate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sdata,
                         input logic [1:0] mtr, input logic rw);
        in_valid      = 1'b1;
        in_MemRead    = rd_en;
        in_MemWrite   = wr_en;
        in_funct3     = f3;
        in_alu_result = alu;
        in_store_data = sdata;
        in_MemtoReg   = mtr;
        in_RegWrite   = rw;
        in_rd_addr    = 5'd5;
        in_pc_write   = 32'h0000_1004;
        in_immediate  = 32'h0000_7000;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_MemRead  = 1'b0;
        in_MemWrite = 1'b0;
        in_RegWrite = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        in_funct3 = 3'b000; in_alu_result = '0; in_store_data = '0; in_MemtoReg = 2'd0;
        in_rd_addr = '0; in_pc_write = '0; in_immediate = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) cyc();
        $display("txn reset");
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rw", 32'(wb_RegWrite), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_wb_data", wb_data_in, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        cyc();

        // LW with zero-wait ack
        $display("txn LW 0x100 ack same cycle");
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2'd1, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lw_req", 32'(dmem_req), 32'd1);
        chk("lw_stall", 32'(stall_req), 32'd0);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_be", 32'(dmem_be), 32'hF);
        chk("lw_we", 32'(dmem_we), 32'd0);
        cyc(); idle(); dmem_ack = 1'b0;
        chk("lw_wb_valid", 32'(wb_valid), 32'd1);
        chk("lw_wb_data", wb_data_in, 32'hDEAD_BEEF);
        chk("lw_wb_rw", 32'(wb_RegWrite), 32'd1);
        chk("lw_wb_rd", 32'(wb_rd_addr), 32'd5);
        chk("lw_wb_mtr", 32'(wb_MemtoReg), 32'd1);

        // LB with three wait cycles
        $display("txn LB 0x103 three wait cycles");
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 2'd1, 1'b1);
        dmem_rdata = 32'h80FF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_stall", 32'(stall_req), 32'd1);
            cyc();
            chk("lb_bubble_valid", 32'(wb_valid), 32'd0);
            chk("lb_bubble_rw", 32'(wb_RegWrite), 32'd0);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("lb_ack_stall", 32'(stall_req), 32'd0);
        cyc();
        chk("lb_wb_data", wb_data_in, 32'hFFFF_FF80);
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);

        $display("txn LBU 0x103");
        drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2'd1, 1'b1);
        cyc();
        chk("lbu_wb_data", wb_data_in, 32'h0000_0080);

        $display("txn LH/LHU 0x102");
        drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2'd1, 1'b1);
        cyc();
        chk("lh_wb_data", wb_data_in, 32'hFFFF_80FF);
        drive(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2'd1, 1'b1);
        cyc(); idle(); dmem_ack = 1'b0;
        chk("lhu_wb_data", wb_data_in, 32'h0000_80FF);

        // Stores
        $display("txn SH 0x202");
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 2'd0, 1'b0);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_addr", dmem_addr, 32'h200);
        cyc();
        $display("txn SB 0x201");
        drive(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_0077, 2'd0, 1'b0);
        @(negedge clk);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h7777_7777);
        cyc();
        $display("txn SW 0x204");
        drive(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 2'd0, 1'b0);
        @(negedge clk);
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        cyc(); idle(); dmem_ack = 1'b0;

        // Misaligned LW
        $display("txn LW 0x101 misaligned");
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 2'd1, 1'b1);
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall_req), 32'd0);
        cyc(); idle();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_wb_rw", 32'(wb_RegWrite), 32'd0);
        cyc();
        chk("mis_err_clear", 32'(misalign_err), 32'd0);

        // Load then ALU op back to back
        $display("txn LW 0x104 then ALU 0x55");
        drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 2'd1, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
        cyc();
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 2'd0, 1'b1);
        dmem_ack = 1'b0;
        chk("b2b_ld_data", wb_data_in, 32'h1122_3344);
        @(negedge clk);
        chk("alu_stall", 32'(stall_req), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        cyc(); idle();
        chk("alu_wb_res", wb_alu_result, 32'h55);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_mtr", 32'(wb_MemtoReg), 32'd0);
        chk("alu_wb_rw", 32'(wb_RegWrite), 32'd1);

        // Reset during an outstanding access, then a late ack
        $display("txn LW 0x300 reset while waiting");
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 2'd1, 1'b1);
        cyc();
        chk("rw_stall", 32'(stall_req), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; idle(); dmem_ack = 1'b1;
        @(negedge clk);
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall_after", 32'(stall_req), 32'd0);
        cyc(); dmem_ack = 1'b0;
        chk("rw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rw_wb_rw", 32'(wb_RegWrite), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
